// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Definitions shared by the write-back/commit stage and its flush controller.
//   wb_state_e   : flush controller state (IDLE, FLUSH)
//   BTYPE_*      : encoding of the branch-type control bit
//   FLUSH_CNT_W  : width of the flush down-counter (covers depths 1..7)
// ---------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

  localparam logic BTYPE_ZERO = 1'b0;
  localparam logic BTYPE_NEG  = 1'b1;

  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/wb_flush_ctrl.sv
// ---------------------------------------------------------------------------
// wb_flush_ctrl
// Flush sequencer: on a taken branch/jump it holds flush high for exactly
// FLUSH_DEPTH cycles, during which the commit stage refuses new entries.
//   clk    in  pipeline clock
//   rst_n  in  asynchronous active-low reset
//   taken  in  a taken branch/jump is committing this cycle
//   flush  out squash request to the IF/ID, ID/EX and EX/WB buffers
//   busy   out commit gate: entries sampled while high are wrong-path
// ---------------------------------------------------------------------------
module wb_flush_ctrl
  import wb_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic taken,
  output logic flush,
  output logic busy
);

  // The count is loaded with DEPTH-1 because the loading edge itself
  // already starts the first flush cycle.
  localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

  wb_state_e               state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign flush = (state_q == FLUSH);
  assign busy  = (state_q == FLUSH);

endmodule

// File: rtl/wb_commit_unit.sv
// ---------------------------------------------------------------------------
// wb_commit_unit
// Write-back/commit stage fed by the EX->WB pipeline register.
//   in_valid/in_ctrl_*  in  registered WB control for the current entry
//   in_memdata/aluresult in candidate write-back values
//   in_target           in  branch/jump target
//   in_rd               in  destination register (r0 is never written)
//   rf_we/waddr/wdata   out registered register-file write port
//   pc_redirect         out one-cycle pulse, PC loads pc_target
//   pc_target           out last redirect address (held)
//   flush               out wrong-path squash, FLUSH_DEPTH cycles long
//   retired_count       out committed instructions (wrapping)
//   taken_count         out taken branches + jumps (wrapping)
// ---------------------------------------------------------------------------
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int RET_W       = 32,
  parameter int TKN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_ctrl_regwrt,
  input  logic             in_ctrl_branch,
  input  logic             in_ctrl_btype,
  input  logic             in_ctrl_jump,
  input  logic             in_ctrl_memtoreg,
  input  logic             in_ctrl_neg,
  input  logic             in_ctrl_zero,
  input  logic [31:0]      in_memdata,
  input  logic [31:0]      in_aluresult,
  input  logic [31:0]      in_target,
  input  logic [5:0]       in_rd,
  output logic             rf_we,
  output logic [5:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush,
  output logic [RET_W-1:0] retired_count,
  output logic [TKN_W-1:0] taken_count
);

  logic busy;
  logic commit;
  logic cond_met;
  logic taken;

  logic             rf_we_q, rf_we_d;
  logic [5:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             redirect_q;
  logic [31:0]      target_q;
  logic [RET_W-1:0] ret_q;
  logic [TKN_W-1:0] tkn_q;

  // Entries arriving while the flush sequencer is busy are wrong-path.
  assign commit = in_valid & ~busy;

  // Jump overrides the branch condition entirely.
  always_comb begin
    cond_met = in_ctrl_jump;
    if (in_ctrl_branch) begin
      if (in_ctrl_btype == BTYPE_NEG) cond_met = cond_met | in_ctrl_neg;
      else                            cond_met = cond_met | in_ctrl_zero;
    end
  end

  assign taken = commit & cond_met;

  assign rf_we_d    = commit & in_ctrl_regwrt & (in_rd != 6'd0);
  assign rf_wdata_d = in_ctrl_memtoreg ? in_memdata : in_aluresult;

  wb_flush_ctrl #(
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) u_flush_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .taken (taken),
    .flush (flush),
    .busy  (busy)
  );

  // Write port keeps its last address/data when idle so the RF sees stable
  // values; a taken instruction still writes its link value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      ret_q      <= '0;
      tkn_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      redirect_q <= taken;
      if (rf_we_d) begin
        rf_waddr_q <= in_rd;
        rf_wdata_q <= rf_wdata_d;
      end
      if (taken) begin
        target_q <= in_target;
        tkn_q    <= tkn_q + TKN_W'(1);
      end
      if (commit) begin
        ret_q <= ret_q + RET_W'(1);
      end
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign pc_redirect   = redirect_q;
  assign pc_target     = target_q;
  assign retired_count = ret_q;
  assign taken_count   = tkn_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

  localparam int FD = 3;

  logic        clk;
  logic        rst_n;
  logic        v, rw, br, bt, jp, m2r, ng, zr;
  logic [31:0] mem, alu, tgt;
  logic [5:0]  rd;

  logic        rf_we, pc_redirect, flush;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_target;
  logic [31:0] retired_count;
  logic [15:0] taken_count;

  // Second instance: shallow flush and narrow counters for the wrap test.
  logic        v2, j2;
  logic [31:0] tgt2;
  logic        we2, rdr2, fl2;
  logic [5:0]  wa2;
  logic [31:0] wd2, tg2;
  logic [7:0]  ret2, tk2;

  int total = 0;
  int bad   = 0;

  wb_commit_unit #(.FLUSH_DEPTH(FD), .RET_W(32), .TKN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v), .in_ctrl_regwrt(rw),
    .in_ctrl_branch(br), .in_ctrl_btype(bt), .in_ctrl_jump(jp),
    .in_ctrl_memtoreg(m2r), .in_ctrl_neg(ng), .in_ctrl_zero(zr),
    .in_memdata(mem), .in_aluresult(alu), .in_target(tgt), .in_rd(rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .retired_count(retired_count), .taken_count(taken_count)
  );

  wb_commit_unit #(.FLUSH_DEPTH(1), .RET_W(8), .TKN_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ctrl_regwrt(1'b0),
    .in_ctrl_branch(1'b0), .in_ctrl_btype(1'b0), .in_ctrl_jump(j2),
    .in_ctrl_memtoreg(1'b0), .in_ctrl_neg(1'b0), .in_ctrl_zero(1'b0),
    .in_memdata(32'h0), .in_aluresult(32'h0), .in_target(tgt2), .in_rd(6'd0),
    .rf_we(we2), .rf_waddr(wa2), .rf_wdata(wd2),
    .pc_redirect(rdr2), .pc_target(tg2), .flush(fl2),
    .retired_count(ret2), .taken_count(tk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining flush cycles plus architectural results.
  int          m_fl;
  logic        m_we, m_redir;
  logic [5:0]  m_waddr;
  logic [31:0] m_wdata, m_target, m_ret;
  logic [15:0] m_tkn;

  task automatic model_reset();
    m_fl = 0; m_we = 0; m_redir = 0; m_waddr = 0;
    m_wdata = 0; m_target = 0; m_ret = 0; m_tkn = 0;
  endtask

  task automatic model_step();
    bit commit, take;
    commit = v && (m_fl == 0);
    if (m_fl > 0) m_fl--;
    take = commit && (jp || (br && (bt ? ng : zr)));
    m_we = commit && rw && (rd != 0);
    if (m_we) begin
      m_waddr = rd;
      m_wdata = m2r ? mem : alu;
    end
    m_redir = take;
    if (take) begin
      m_target = tgt;
      m_tkn++;
      m_fl = FD;
    end
    if (commit) m_ret++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".we"},  32'(rf_we),       32'(m_we));
    chk({tag, ".wa"},  32'(rf_waddr),    32'(m_waddr));
    chk({tag, ".wd"},  rf_wdata,         m_wdata);
    chk({tag, ".rdr"}, 32'(pc_redirect), 32'(m_redir));
    chk({tag, ".tgt"}, pc_target,        m_target);
    chk({tag, ".fl"},  32'(flush),       32'(m_fl > 0));
    chk({tag, ".ret"}, retired_count,    m_ret);
    chk({tag, ".tkn"}, 32'(taken_count), 32'(m_tkn));
  endtask

  task automatic idle_inputs();
    v = 0; rw = 0; br = 0; bt = 0; jp = 0; m2r = 0; ng = 0; zr = 0;
    mem = 0; alu = 0; tgt = 0; rd = 0;
  endtask

  typedef struct packed {
    logic v, rw, br, bt, jp, m2r, ng, zr;
    logic [31:0] mem, alu, tgt;
    logic [5:0]  rd;
    logic        e_we;
    logic [5:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdr, e_fl;
    logic [31:0] e_tg, e_ret;
    logic [15:0] e_tk;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_n = 0; v2 = 0; j2 = 0; tgt2 = 0;
    idle_inputs();
    model_reset();

    //                  v    rw   br   bt   jp   m2r  ng   zr   mem           alu           tgt           rd      we   wa      wd            rdr  fl   tg            ret       tk
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hA5,       32'h0,   6'd7,  1'b1,6'd7,  32'hA5,       1'b0,1'b0,32'h0,   32'd1,16'd0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hDEADBEEF, 32'h0,        32'h0,   6'd0,  1'b0,6'd7,  32'hA5,       1'b0,1'b0,32'h0,   32'd2,16'd0};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0,        32'h40,  6'd0,  1'b0,6'd7,  32'hA5,       1'b1,1'b1,32'h40,  32'd3,16'd1};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h111,      32'h0,   6'd1,  1'b0,6'd7,  32'hA5,       1'b0,1'b1,32'h40,  32'd3,16'd1};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h222,      32'h0,   6'd2,  1'b0,6'd7,  32'hA5,       1'b0,1'b1,32'h40,  32'd3,16'd1};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h333,      32'h0,   6'd3,  1'b0,6'd7,  32'hA5,       1'b0,1'b0,32'h40,  32'd3,16'd1};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h55,       32'h0,   6'd5,  1'b1,6'd5,  32'h55,       1'b0,1'b0,32'h40,  32'd4,16'd1};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h1234,     32'h80,  6'd31, 1'b1,6'd31, 32'h1234,     1'b1,1'b1,32'h80,  32'd5,16'd2};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,   6'd0,  1'b0,6'd31, 32'h1234,     1'b0,1'b1,32'h80,  32'd5,16'd2};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,   6'd0,  1'b0,6'd31, 32'h1234,     1'b0,1'b1,32'h80,  32'd5,16'd2};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,   6'd0,  1'b0,6'd31, 32'h1234,     1'b0,1'b0,32'h80,  32'd5,16'd2};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hCAFEF00D, 32'h9,        32'h0,   6'd63, 1'b1,6'd63, 32'hCAFEF00D, 1'b0,1'b0,32'h80,  32'd6,16'd2};
    tbl[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h100, 6'd0,  1'b0,6'd63, 32'hCAFEF00D, 1'b1,1'b1,32'h100, 32'd7,16'd3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    rst_n = 1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      v = tbl[i].v; rw = tbl[i].rw; br = tbl[i].br; bt = tbl[i].bt;
      jp = tbl[i].jp; m2r = tbl[i].m2r; ng = tbl[i].ng; zr = tbl[i].zr;
      mem = tbl[i].mem; alu = tbl[i].alu; tgt = tbl[i].tgt; rd = tbl[i].rd;
      tick();
      chk($sformatf("row%0d.we", i),  32'(rf_we),         32'(tbl[i].e_we));
      chk($sformatf("row%0d.wa", i),  32'(rf_waddr),      32'(tbl[i].e_wa));
      chk($sformatf("row%0d.wd", i),  rf_wdata,           tbl[i].e_wd);
      chk($sformatf("row%0d.rdr", i), 32'(pc_redirect),   32'(tbl[i].e_rdr));
      chk($sformatf("row%0d.fl", i),  32'(flush),         32'(tbl[i].e_fl));
      chk($sformatf("row%0d.tgt", i), pc_target,          tbl[i].e_tg);
      chk($sformatf("row%0d.ret", i), retired_count,      tbl[i].e_ret);
      chk($sformatf("row%0d.tkn", i), 32'(taken_count),   32'(tbl[i].e_tk));
    end

    // Reset during the second flush cycle
    idle_inputs();
    tick();
    chk("midflush.fl_before", 32'(flush), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst.fl",  32'(flush),         32'd0);
    chk("rst.rdr", 32'(pc_redirect),   32'd0);
    chk("rst.we",  32'(rf_we),         32'd0);
    chk("rst.ret", retired_count,      32'd0);
    chk("rst.tkn", 32'(taken_count),   32'd0);
    chk("rst.tgt", pc_target,          32'd0);
    @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
    v = 1; rw = 1; alu = 32'h99; rd = 6'd9;
    tick();
    chk("postrst.we",  32'(rf_we),    32'd1);
    chk("postrst.wa",  32'(rf_waddr), 32'd9);
    chk("postrst.wd",  rf_wdata,      32'h99);
    chk("postrst.ret", retired_count, 32'd1);
    chk("postrst.fl",  32'(flush),    32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom % 4) != 0;
      rw  = $urandom % 2;
      br  = ($urandom % 4) == 0;
      bt  = $urandom % 2;
      jp  = ($urandom % 8) == 0;
      m2r = $urandom % 2;
      ng  = $urandom % 2;
      zr  = $urandom % 2;
      mem = $urandom;
      alu = $urandom;
      tgt = $urandom;
      rd  = (($urandom % 5) == 0) ? 6'd0 : 6'($urandom);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end
    idle_inputs();

    // Counter wrap and single-cycle flush on the narrow instance
    v2 = 1; j2 = 1; tgt2 = 32'h200;
    @(posedge clk); #1;
    chk("d1.fl",  32'(fl2),  32'd1);
    chk("d1.rdr", 32'(rdr2), 32'd1);
    chk("d1.tgt", tg2,       32'h200);
    chk("d1.tkn", 32'(tk2),  32'd1);
    @(posedge clk); #1;
    chk("d1.fl_end",  32'(fl2),  32'd0);
    chk("d1.rdr_end", 32'(rdr2), 32'd0);
    chk("d1.squash",  32'(tk2),  32'd1);
    chk("d1.ret",     32'(ret2), 32'd1);
    for (int i = 0; i < 254; i++) begin
      repeat (2) @(posedge clk);
    end
    #1;
    chk("wrap.tkn_ff", 32'(tk2),  32'hFF);
    chk("wrap.ret_ff", 32'(ret2), 32'hFF);
    chk("wrap.fl",     32'(fl2),  32'd0);
    @(posedge clk); #1;
    chk("wrap.tkn_0",  32'(tk2),  32'h00);
    chk("wrap.ret_0",  32'(ret2), 32'h00);
    chk("wrap.rdr",    32'(rdr2), 32'd1);
    chk("wrap.we",     32'(we2),  32'd0);
    chk("wrap.wa",     32'(wa2),  32'd0);
    chk("wrap.wd",     wd2,       32'd0);
    @(posedge clk); #1;
    chk("wrap.fl_end", 32'(fl2),  32'd0);
    v2 = 0; j2 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
